control_decode_pipe: RTL and testbench
======================================

Name: control_decode_pipe

Overview:
Parametrised successor to the single-cycle main decoder for the pipelined RV32 core. Decodes the full RV32I base opcode set, plus the optional M extension, from the D-stage instruction. Registers all control signals into the ID/EX boundary. Holds the E stage for a configurable number of cycles on multiply/divide, and raises a busy stall request to the hazard unit while doing so.

Parameters:
ENABLE_M, 1, 1 decodes R-type funct7=0000001 as MUL/DIV; 0 flags it illegal
MUL_LATENCY, 2, cycles a MUL-class op (funct3[2]=0) occupies E; legal range 1..15
DIV_LATENCY, 8, cycles a DIV/REM-class op (funct3[2]=1) occupies E; legal range 1..15

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous, active-high reset
instr_D  in  32  D-stage instruction
valid_D  in  1  instr_D holds a real instruction
flush_E  in  1  from hazard unit: insert bubble into E
ImmSrcD  out  3  combinational: 000 I, 001 S, 010 B, 011 J, 100 U
busy  out  1  E held by multicycle op; hazard unit stalls F/D
validE  out  1  E holds a real instruction
illegalE  out  1  E instruction undecodable
RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE, JalrE, ASrcPCE, MulDivE  out  1 each  registered control
ResultSrcE  out  2  00 ALU, 01 memory, 10 PC+4, 11 immediate (LUI)
ALUOpE  out  2  00 add, 01 branch compare, 10 R-type funct decode, 11 I-type funct decode

Behaviour:
- Decode, combinational on instr_D[6:0]:
  - lw 0000011: RegWrite, ALUSrc, ResultSrc=01, ALUOp=00, Imm I.
  - sw 0100011: MemWrite, ALUSrc, ALUOp=00, Imm S.
  - R 0110011: RegWrite, ALUOp=10.
  - branch 1100011, any funct3: Branch, ALUOp=01, Imm B.
  - jal 1101111: RegWrite, Jump, ResultSrc=10, Imm J.
  - jalr 1100111: RegWrite, Jump, Jalr, ALUSrc, ResultSrc=10, Imm I.
  - imm 0010011: RegWrite, ALUSrc, ALUOp=11.
  - lui 0110111: RegWrite, ResultSrc=11, Imm U.
  - auipc 0010111: RegWrite, ALUSrc, ASrcPC, ALUOp=00, Imm U.
- Signals not listed for an opcode are 0. ImmSrcD defaults to 000.
- MulDiv=1 iff the opcode is R-type, funct7=0000001 and ENABLE_M=1.
- Illegal when any of these holds:
  - instr_D[1:0]!=11;
  - the opcode is unlisted;
  - R-type with funct7 not 0000000/0100000 (and not 0000001 when ENABLE_M=1).
- For an illegal instruction: all write/branch/jump enables are 0, illegal=1, and the instruction is still valid.
- E register update on each rising clk, first matching rule wins:
  1. rst: all E outputs 0, counter=0.
  2. flush_E: all E outputs 0 (bubble), counter=0; aborts any multicycle hold.
  3. counter!=0: E outputs held, counter decrements.
  4. Otherwise: capture decode of instr_D, with validE=valid_D. When valid_D=0, every E enable and illegalE are forced to 0.
- Counter:
  - 4-bit.
  - On a capture with MulDiv=1 and valid_D=1, load MUL_LATENCY-1 or DIV_LATENCY-1 (selected by funct3[2]); otherwise load 0.
  - busy = (counter!=0), driven from the register only, never combinationally from instr_D.
- Timing:
  - A multicycle op stays in E for exactly LATENCY cycles; the next D instruction is captured on the edge at which counter goes 1->0.
  - LATENCY=1 gives no hold and busy is never asserted.
- Asynchronous reset mid-hold: all outputs and counter go to 0 immediately, without waiting for a clock edge; busy deasserts the same instant.
- ImmSrcD depends only on instr_D and is unaffected by rst, busy and flush_E.

Test Plan:
1. Assert rst asynchronously between clock edges -> all E outputs and busy go to 0 immediately. Release rst, drive lw 0x00012083 with valid_D=1 -> next edge RegWriteE=1, ALUSrcE=1, ResultSrcE=01, ALUOpE=00, validE=1, ImmSrcD=000.
2. Drive sequence add 0x002081B3, lui 0x123452B7, auipc 0x00000297, jalr 0x000080E7 -> per cycle:
   - add: ALUOpE=10;
   - lui: ResultSrcE=11, ImmSrcD=100;
   - auipc: ASrcPCE=1, ALUSrcE=1;
   - jalr: JumpE=1, JalrE=1, ResultSrcE=10.
3. With MUL_LATENCY=2, drive mul 0x022081B3 then add -> MulDivE=1 for 2 cycles, busy=1 for exactly 1 cycle, add appears in E on the third edge. With DIV_LATENCY=8 and div 0x0220C1B3 -> busy high for 7 cycles.
4. Assert flush_E in the third cycle of a div hold -> next edge validE=0, MulDivE=0, busy=0; the following edge captures instr_D.
5. Drive instr 0x00000000, then mul with ENABLE_M=0 -> illegalE=1, validE=1, RegWriteE=0, MemWriteE=0, busy=0 in both cases.
6. Drive valid_D=0 with a sw encoding 0x00112023 -> MemWriteE=0, validE=0, illegalE=0, while ImmSrcD=001.

Source files
------------

// File: rtl/control_decode_pipe.sv
// control_decode_pipe: RV32I (+ optional M) main decoder feeding the ID/EX
// register. Multiply/divide ops hold the E stage for a configurable number
// of cycles and raise busy so the hazard unit stalls F/D meanwhile.
module control_decode_pipe #(
  parameter bit          ENABLE_M    = 1'b1,
  parameter int unsigned MUL_LATENCY = 2,
  parameter int unsigned DIV_LATENCY = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_D,
  input  logic        valid_D,
  input  logic        flush_E,
  output logic [2:0]  ImmSrcD,
  output logic        busy,
  output logic        validE,
  output logic        illegalE,
  output logic        RegWriteE,
  output logic        MemWriteE,
  output logic        ALUSrcE,
  output logic        BranchE,
  output logic        JumpE,
  output logic        JalrE,
  output logic        ASrcPCE,
  output logic        MulDivE,
  output logic [1:0]  ResultSrcE,
  output logic [1:0]  ALUOpE
);

  // Counter reload values: an op of latency N stays N cycles, so N-1 extra
  localparam logic [3:0] mulLoad = 4'(MUL_LATENCY - 1);
  localparam logic [3:0] divLoad = 4'(DIV_LATENCY - 1);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic       regWriteD, memWriteD, aluSrcD, branchD, jumpD, jalrD;
  logic       aSrcPcD, mulDivD, illegalD;
  logic [1:0] resultSrcD, aluOpD;
  logic [3:0] holdCount;

  assign opcode = instr_D[6:0];
  assign funct7 = instr_D[31:25];
  assign busy   = (holdCount != 4'd0);

  // Opcode decode; an illegal instruction leaves every control at zero
  always_comb begin
    regWriteD  = 1'b0;
    memWriteD  = 1'b0;
    aluSrcD    = 1'b0;
    branchD    = 1'b0;
    jumpD      = 1'b0;
    jalrD      = 1'b0;
    aSrcPcD    = 1'b0;
    mulDivD    = 1'b0;
    illegalD   = 1'b0;
    resultSrcD = 2'b00;
    aluOpD     = 2'b00;
    ImmSrcD    = 3'b000;
    case (opcode)
      7'b0000011: begin
        regWriteD  = 1'b1;
        aluSrcD    = 1'b1;
        resultSrcD = 2'b01;
      end
      7'b0100011: begin
        memWriteD = 1'b1;
        aluSrcD   = 1'b1;
        ImmSrcD   = 3'b001;
      end
      7'b0110011: begin
        regWriteD = 1'b1;
        aluOpD    = 2'b10;
        if (funct7 == 7'b0000001 && ENABLE_M) begin
          mulDivD = 1'b1;
        end else if (funct7 != 7'b0000000 && funct7 != 7'b0100000) begin
          illegalD = 1'b1;
        end
      end
      7'b1100011: begin
        branchD = 1'b1;
        aluOpD  = 2'b01;
        ImmSrcD = 3'b010;
      end
      7'b1101111: begin
        regWriteD  = 1'b1;
        jumpD      = 1'b1;
        resultSrcD = 2'b10;
        ImmSrcD    = 3'b011;
      end
      7'b1100111: begin
        regWriteD  = 1'b1;
        jumpD      = 1'b1;
        jalrD      = 1'b1;
        aluSrcD    = 1'b1;
        resultSrcD = 2'b10;
      end
      7'b0010011: begin
        regWriteD = 1'b1;
        aluSrcD   = 1'b1;
        aluOpD    = 2'b11;
      end
      7'b0110111: begin
        regWriteD  = 1'b1;
        resultSrcD = 2'b11;
        ImmSrcD    = 3'b100;
      end
      7'b0010111: begin
        regWriteD = 1'b1;
        aluSrcD   = 1'b1;
        aSrcPcD   = 1'b1;
        ImmSrcD   = 3'b100;
      end
      default: illegalD = 1'b1;
    endcase
    if (instr_D[1:0] != 2'b11) begin
      illegalD = 1'b1;
    end
    if (illegalD) begin
      regWriteD  = 1'b0;
      memWriteD  = 1'b0;
      aluSrcD    = 1'b0;
      branchD    = 1'b0;
      jumpD      = 1'b0;
      jalrD      = 1'b0;
      aSrcPcD    = 1'b0;
      mulDivD    = 1'b0;
      resultSrcD = 2'b00;
      aluOpD     = 2'b00;
    end
  end

  // ID/EX register: reset/flush clear it, a running hold freezes it, else capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst || flush_E) begin
      validE     <= 1'b0;
      illegalE   <= 1'b0;
      RegWriteE  <= 1'b0;
      MemWriteE  <= 1'b0;
      ALUSrcE    <= 1'b0;
      BranchE    <= 1'b0;
      JumpE      <= 1'b0;
      JalrE      <= 1'b0;
      ASrcPCE    <= 1'b0;
      MulDivE    <= 1'b0;
      ResultSrcE <= 2'b00;
      ALUOpE     <= 2'b00;
      holdCount  <= 4'd0;
    end else if (holdCount != 4'd0) begin
      holdCount <= holdCount - 4'd1;
    end else begin
      validE     <= valid_D;
      illegalE   <= valid_D & illegalD;
      RegWriteE  <= valid_D & regWriteD;
      MemWriteE  <= valid_D & memWriteD;
      ALUSrcE    <= valid_D & aluSrcD;
      BranchE    <= valid_D & branchD;
      JumpE      <= valid_D & jumpD;
      JalrE      <= valid_D & jalrD;
      ASrcPCE    <= valid_D & aSrcPcD;
      MulDivE    <= valid_D & mulDivD;
      ResultSrcE <= valid_D ? resultSrcD : 2'b00;
      ALUOpE     <= valid_D ? aluOpD : 2'b00;
      if (valid_D && mulDivD) begin
        holdCount <= instr_D[14] ? divLoad : mulLoad;
      end else begin
        holdCount <= 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_control_decode_pipe.sv
// tb_control_decode_pipe: table-driven vectors plus hand sequences for the
// multicycle hold, flush abort and asynchronous reset; a second instance
// built without the M extension sees the same stimulus.
module tb_control_decode_pipe;

  typedef struct packed {
    logic       validE, illegalE, RegWriteE, MemWriteE, ALUSrcE, BranchE;
    logic       JumpE, JalrE, ASrcPCE, MulDivE, busy;
    logic [1:0] ResultSrcE, ALUOpE;
  } eState_t;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        valid;
    logic [2:0]  imm;
    eState_t     exp;
  } vec_t;

  logic        clk, rst, valid_D, flush_E;
  logic [31:0] instr_D;
  logic [2:0]  ImmSrcD, ImmSrcDNoM;
  logic        busy, validE, illegalE, RegWriteE, MemWriteE, ALUSrcE, BranchE;
  logic        JumpE, JalrE, ASrcPCE, MulDivE;
  logic [1:0]  ResultSrcE, ALUOpE;
  logic        busyN, validEN, illegalEN, RegWriteEN, MemWriteEN, ALUSrcEN, BranchEN;
  logic        JumpEN, JalrEN, ASrcPCEN, MulDivEN;
  logic [1:0]  ResultSrcEN, ALUOpEN;

  eState_t actMain, actNoM;
  eState_t expQ[$];
  vec_t    vecs[$];
  int      numVectors = 0;
  int      numMiscompares = 0;

  localparam logic [31:0] LW   = 32'h00012083, ADD  = 32'h002081B3;
  localparam logic [31:0] LUI  = 32'h123452B7, AUIPC = 32'h00000297;
  localparam logic [31:0] JALR = 32'h000080E7, SW   = 32'h00112023;
  localparam logic [31:0] MUL  = 32'h022081B3, DIV  = 32'h0220C1B3;

  assign actMain = {validE, illegalE, RegWriteE, MemWriteE, ALUSrcE, BranchE,
                    JumpE, JalrE, ASrcPCE, MulDivE, busy, ResultSrcE, ALUOpE};
  assign actNoM  = {validEN, illegalEN, RegWriteEN, MemWriteEN, ALUSrcEN, BranchEN,
                    JumpEN, JalrEN, ASrcPCEN, MulDivEN, busyN, ResultSrcEN, ALUOpEN};

  control_decode_pipe #(.ENABLE_M(1'b1), .MUL_LATENCY(2), .DIV_LATENCY(8)) dut (
    .clk(clk), .rst(rst), .instr_D(instr_D), .valid_D(valid_D), .flush_E(flush_E),
    .ImmSrcD(ImmSrcD), .busy(busy), .validE(validE), .illegalE(illegalE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ALUSrcE(ALUSrcE),
    .BranchE(BranchE), .JumpE(JumpE), .JalrE(JalrE), .ASrcPCE(ASrcPCE),
    .MulDivE(MulDivE), .ResultSrcE(ResultSrcE), .ALUOpE(ALUOpE)
  );

  control_decode_pipe #(.ENABLE_M(1'b0), .MUL_LATENCY(2), .DIV_LATENCY(8)) dutNoM (
    .clk(clk), .rst(rst), .instr_D(instr_D), .valid_D(valid_D), .flush_E(flush_E),
    .ImmSrcD(ImmSrcDNoM), .busy(busyN), .validE(validEN), .illegalE(illegalEN),
    .RegWriteE(RegWriteEN), .MemWriteE(MemWriteEN), .ALUSrcE(ALUSrcEN),
    .BranchE(BranchEN), .JumpE(JumpEN), .JalrE(JalrEN), .ASrcPCE(ASrcPCEN),
    .MulDivE(MulDivEN), .ResultSrcE(ResultSrcEN), .ALUOpE(ALUOpEN)
  );

  // Free-running core clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run can never hang
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic eState_t ctl(input logic v, il, rw, mw, as, br, j, jr, ap, md, bz,
                                  input logic [1:0] rs, aop);
    return '{v, il, rw, mw, as, br, j, jr, ap, md, bz, rs, aop};
  endfunction

  task automatic compareState(input string name, input eState_t got, input eState_t want);
    numVectors++;
    if (got !== want) begin
      numMiscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  task automatic checkOutput(input string name);
    eState_t want;
    want = expQ.pop_front();
    compareState(name, actMain, want);
  endtask

  task automatic applyStimulus(input string name, input logic [31:0] instr,
                               input logic valid, input logic flush,
                               input logic [2:0] immExp, input eState_t exp);
    @(negedge clk);
    instr_D = instr;
    valid_D = valid;
    flush_E = flush;
    #1;
    numVectors++;
    if (ImmSrcD !== immExp) begin
      numMiscompares++;
      $display("[TB] FAIL %s ImmSrcD: got %b, expected %b", name, ImmSrcD, immExp);
    end
    expQ.push_back(exp);
    @(posedge clk);
    #1;
    checkOutput(name);
  endtask

  initial begin
    eState_t zero, mulExp, divExp, addExp, illExp;
    zero   = '0;
    addExp = ctl(1,0,1,0,0,0,0,0,0,0,0,2'b00,2'b10);
    mulExp = ctl(1,0,1,0,0,0,0,0,0,1,1,2'b00,2'b10);
    illExp = ctl(1,1,0,0,0,0,0,0,0,0,0,2'b00,2'b00);

    vecs.push_back('{"lw",     LW,           1'b1, 3'b000, ctl(1,0,1,0,1,0,0,0,0,0,0,2'b01,2'b00)});
    vecs.push_back('{"add",    ADD,          1'b1, 3'b000, addExp});
    vecs.push_back('{"lui",    LUI,          1'b1, 3'b100, ctl(1,0,1,0,0,0,0,0,0,0,0,2'b11,2'b00)});
    vecs.push_back('{"auipc",  AUIPC,        1'b1, 3'b100, ctl(1,0,1,0,1,0,0,0,1,0,0,2'b00,2'b00)});
    vecs.push_back('{"jalr",   JALR,         1'b1, 3'b000, ctl(1,0,1,0,1,0,1,1,0,0,0,2'b10,2'b00)});
    vecs.push_back('{"sw",     SW,           1'b1, 3'b001, ctl(1,0,0,1,1,0,0,0,0,0,0,2'b00,2'b00)});
    vecs.push_back('{"beq",    32'h00208463, 1'b1, 3'b010, ctl(1,0,0,0,0,1,0,0,0,0,0,2'b00,2'b01)});
    vecs.push_back('{"jal",    32'h008000EF, 1'b1, 3'b011, ctl(1,0,1,0,0,0,1,0,0,0,0,2'b10,2'b00)});
    vecs.push_back('{"addi",   32'h00108093, 1'b1, 3'b000, ctl(1,0,1,0,1,0,0,0,0,0,0,2'b00,2'b11)});
    vecs.push_back('{"sub",    32'h402081B3, 1'b1, 3'b000, addExp});
    vecs.push_back('{"badR",   32'h202081B3, 1'b1, 3'b000, illExp});
    vecs.push_back('{"zero",   32'h00000000, 1'b1, 3'b000, illExp});
    vecs.push_back('{"low01",  32'h00012080, 1'b1, 3'b000, illExp});
    vecs.push_back('{"swNoV",  SW,           1'b0, 3'b001, zero});

    rst = 1'b1; instr_D = '0; valid_D = 1'b0; flush_E = 1'b0;
    #3;
    compareState("resetMain", actMain, zero);
    compareState("resetNoM", actNoM, zero);
    @(negedge clk);
    rst = 1'b0;

    // Single-cycle table: both builds must agree on every non-M encoding
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].name, vecs[i].instr, vecs[i].valid, 1'b0, vecs[i].imm, vecs[i].exp);
      compareState({vecs[i].name, "NoM"}, actNoM, vecs[i].exp);
    end

    // MUL latency 2: two cycles in E, busy for one, add captured on third edge
    applyStimulus("mul1", MUL, 1'b1, 1'b0, 3'b000, mulExp);
    compareState("mulNoM", actNoM, illExp);
    mulExp.busy = 1'b0;
    applyStimulus("mul2", ADD, 1'b1, 1'b0, 3'b000, mulExp);
    applyStimulus("mulNext", ADD, 1'b1, 1'b0, 3'b000, addExp);

    // DIV latency 8: busy for seven cycles, next op on ninth edge
    for (int k = 1; k <= 8; k++) begin
      divExp = ctl(1,0,1,0,0,0,0,0,0,1,(k < 8),2'b00,2'b10);
      applyStimulus($sformatf("div%0d", k), (k == 1) ? DIV : LUI, 1'b1, 1'b0,
                    (k == 1) ? 3'b000 : 3'b100, divExp);
    end
    applyStimulus("divNext", ADD, 1'b1, 1'b0, 3'b000, addExp);

    // Flush during the third hold cycle aborts the divide
    divExp = ctl(1,0,1,0,0,0,0,0,0,1,1,2'b00,2'b10);
    applyStimulus("flDiv1", DIV, 1'b1, 1'b0, 3'b000, divExp);
    applyStimulus("flDiv2", ADD, 1'b1, 1'b0, 3'b000, divExp);
    applyStimulus("flDiv3", ADD, 1'b1, 1'b0, 3'b000, divExp);
    applyStimulus("flBubble", ADD, 1'b1, 1'b1, 3'b000, zero);
    applyStimulus("flNext", ADD, 1'b1, 1'b0, 3'b000, addExp);

    // Asynchronous reset in the middle of a divide hold
    applyStimulus("rsDiv1", DIV, 1'b1, 1'b0, 3'b000, divExp);
    applyStimulus("rsDiv2", ADD, 1'b1, 1'b0, 3'b000, divExp);
    #2;
    rst = 1'b1;
    #1;
    compareState("asyncReset", actMain, zero);
    #1;
    rst = 1'b0;
    applyStimulus("rsNext", ADD, 1'b1, 1'b0, 3'b000, addExp);

    $display("== %0d vectors applied, %0d miscompares ==", numVectors, numMiscompares);
    $finish;
  end

endmodule
